// File: rtl/global_buffer_param.sv
// Global buffer width constants shared by the tile chain and its processor-side injector.
package global_buffer_param;

    localparam int GLB_ADDR_WIDTH  = 22;
    localparam int BANK_DATA_WIDTH = 64;
    localparam int BANK_STRB_WIDTH = BANK_DATA_WIDTH / 8;

endpackage

// File: rtl/global_buffer_pkg.sv
// Packet types carried along the global buffer tile chain, plus the read-tracker state enum.
package global_buffer_pkg;

    import global_buffer_param::*;

    typedef struct packed {
        logic                       wr_en;
        logic [BANK_STRB_WIDTH-1:0] wr_strb;
        logic [GLB_ADDR_WIDTH-1:0]  wr_addr;
        logic [BANK_DATA_WIDTH-1:0] wr_data;
    } wr_packet_t;

    typedef struct packed {
        logic                      rd_en;
        logic [GLB_ADDR_WIDTH-1:0] rd_addr;
    } rdrq_packet_t;

    typedef struct packed {
        logic [BANK_DATA_WIDTH-1:0] rd_data;
        logic                       rd_data_valid;
    } rdrs_packet_t;

    typedef struct packed {
        wr_packet_t   wr;
        rdrq_packet_t rdrq;
        rdrs_packet_t rdrs;
    } packet_t;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } rd_state_e;

endpackage

// File: rtl/glb_proc_packet_injector_if.sv
// Processor write/read bus; the processor is the master, the packet injector the slave.
interface glb_proc_packet_injector_if;

    import global_buffer_param::*;

    logic                       proc_wr_en;
    logic [BANK_STRB_WIDTH-1:0] proc_wr_strb;
    logic [GLB_ADDR_WIDTH-1:0]  proc_wr_addr;
    logic [BANK_DATA_WIDTH-1:0] proc_wr_data;
    logic                       proc_rd_en;
    logic [GLB_ADDR_WIDTH-1:0]  proc_rd_addr;
    logic                       proc_rd_ready;
    logic [BANK_DATA_WIDTH-1:0] proc_rd_data;
    logic                       proc_rd_data_valid;
    logic                       proc_rd_err;

    modport master (
        output proc_wr_en, proc_wr_strb, proc_wr_addr, proc_wr_data,
        output proc_rd_en, proc_rd_addr,
        input  proc_rd_ready, proc_rd_data, proc_rd_data_valid, proc_rd_err
    );

    modport slave (
        input  proc_wr_en, proc_wr_strb, proc_wr_addr, proc_wr_data,
        input  proc_rd_en, proc_rd_addr,
        output proc_rd_ready, proc_rd_data, proc_rd_data_valid, proc_rd_err
    );

endinterface

// File: rtl/glb_proc_rd_tracker.sv
// Single-outstanding read tracker: FSM, response capture and sticky error flag.
// Optional read timeout enabled by defining GLB_PROC_RD_TIMEOUT_EN.
module glb_proc_rd_tracker
    import global_buffer_pkg::*;
`ifdef GLB_PROC_RD_TIMEOUT_EN
#(
    parameter int RD_TIMEOUT_CYCLES = 256
)
`endif
(
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             rd_req,
    input  rdrs_packet_t                     rsp,
    output logic                             rd_accept,
    output logic                             rd_ready,
    output logic [$bits(rsp.rd_data)-1:0]    rd_data,
    output logic                             rd_data_valid,
    output logic                             rd_err
);

    rd_state_e state, state_next;
    logic      rsp_hit;
    logic      stray;
    logic      timeout;

`ifdef GLB_PROC_RD_TIMEOUT_EN
    localparam int CNT_W = $clog2(RD_TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;

    // Held at zero outside RD_WAIT so it always starts from zero on entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wait_cnt <= '0;
        else if (state == IDLE)
            wait_cnt <= '0;
        else if (wait_cnt != CNT_W'(RD_TIMEOUT_CYCLES))
            wait_cnt <= wait_cnt + 1'b1;
    end

    assign timeout = (state == RD_WAIT) && !rsp.rd_data_valid &&
                     (wait_cnt == CNT_W'(RD_TIMEOUT_CYCLES));
`else
    assign timeout = 1'b0;
`endif

    // NOTE: state and every registered output use <= so all flops update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // NOTE: every signal written here gets a default first, otherwise a missed branch infers a latch.
    always_comb begin
        state_next = state;
        rd_accept  = 1'b0;
        rsp_hit    = 1'b0;
        stray      = 1'b0;
        case (state)
            IDLE: begin
                rd_accept = rd_req;
                stray     = rsp.rd_data_valid;
                if (rd_req)
                    state_next = RD_WAIT;
            end
            RD_WAIT: begin
                rsp_hit = rsp.rd_data_valid;
                if (rsp.rd_data_valid || timeout)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data       <= '0;
            rd_data_valid <= 1'b0;
            rd_err        <= 1'b0;
        end else begin
            rd_data_valid <= rsp_hit || timeout;
            if (rsp_hit)
                rd_data <= rsp.rd_data;
            else if (timeout)
                rd_data <= '0;
            if (stray || timeout)
                rd_err <= 1'b1;
        end
    end

    assign rd_ready = (state == IDLE);

endmodule

// File: rtl/glb_proc_packet_injector.sv
// Processor-side initiator at the west edge of the global buffer tile chain.
// Optional read timeout enabled by defining GLB_PROC_RD_TIMEOUT_EN.
module glb_proc_packet_injector
    import global_buffer_pkg::*;
#(
    parameter int RD_TIMEOUT_CYCLES = 256
)
(
    input  logic                       clk,
    input  logic                       reset,
    glb_proc_packet_injector_if.slave  proc_if,
    output packet_t                    packet_w2e_esto,
    input  packet_t                    packet_e2w_wsti
);

    wr_packet_t   wr_q;
    rdrq_packet_t rdrq_q;
    logic         rd_accept;
    logic         unused_e2w_fields;

    // Only read responses come back on the west output; the other fields are ignored.
    assign unused_e2w_fields = ^{packet_e2w_wsti.wr, packet_e2w_wsti.rdrq};

    glb_proc_rd_tracker
`ifdef GLB_PROC_RD_TIMEOUT_EN
    #(
        .RD_TIMEOUT_CYCLES (RD_TIMEOUT_CYCLES)
    )
`endif
    u_rd_tracker (
        .clk           (clk),
        .reset         (reset),
        .rd_req        (proc_if.proc_rd_en),
        .rsp           (packet_e2w_wsti.rdrs),
        .rd_accept     (rd_accept),
        .rd_ready      (proc_if.proc_rd_ready),
        .rd_data       (proc_if.proc_rd_data),
        .rd_data_valid (proc_if.proc_rd_data_valid),
        .rd_err        (proc_if.proc_rd_err)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q   <= '0;
            rdrq_q <= '0;
        end else begin
            if (proc_if.proc_wr_en) begin
                wr_q.wr_en   <= 1'b1;
                wr_q.wr_strb <= proc_if.proc_wr_strb;
                wr_q.wr_addr <= proc_if.proc_wr_addr;
                wr_q.wr_data <= proc_if.proc_wr_data;
            end else begin
                wr_q <= '0;
            end
            if (rd_accept) begin
                rdrq_q.rd_en   <= 1'b1;
                rdrq_q.rd_addr <= proc_if.proc_rd_addr;
            end else begin
                rdrq_q <= '0;
            end
        end
    end

    assign packet_w2e_esto.wr   = wr_q;
    assign packet_w2e_esto.rdrq = rdrq_q;
    assign packet_w2e_esto.rdrs = '0;

endmodule

// File: tb/tb_glb_proc_packet_injector.sv
// Self-checking bench for glb_proc_packet_injector: directed scenarios plus a randomized run
// against a transaction-level model. Define GLB_PROC_RD_TIMEOUT_EN to exercise the timeout.
module tb_glb_proc_packet_injector;

    import global_buffer_param::*;
    import global_buffer_pkg::*;

    localparam int TO_CYCLES = 8;

    logic    clk = 1'b0;
    logic    reset;
    packet_t pkt_out;
    packet_t pkt_in;
    int      n_checks = 0;
    int      n_fail   = 0;

    always #5 clk = ~clk;

    glb_proc_packet_injector_if pif ();

    glb_proc_packet_injector #(.RD_TIMEOUT_CYCLES(TO_CYCLES)) dut (
        .clk             (clk),
        .reset           (reset),
        .proc_if         (pif.slave),
        .packet_w2e_esto (pkt_out),
        .packet_e2w_wsti (pkt_in)
    );

    task automatic idle_inputs();
        pif.proc_wr_en   = 1'b0;
        pif.proc_wr_strb = '0;
        pif.proc_wr_addr = '0;
        pif.proc_wr_data = '0;
        pif.proc_rd_en   = 1'b0;
        pif.proc_rd_addr = '0;
        pkt_in           = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic send_rsp(input logic [BANK_DATA_WIDTH-1:0] d);
        pkt_in.rdrs.rd_data       = d;
        pkt_in.rdrs.rd_data_valid = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (pkt_out !== '0) begin n_fail++; $display("FAIL reset_pkt: got %h want 0", pkt_out); end
        n_checks++;
        if ({pif.proc_rd_ready, pif.proc_rd_data_valid, pif.proc_rd_err} !== 3'b100) begin
            n_fail++; $display("FAIL reset_flags: got rdy/vld/err %b want 100",
                               {pif.proc_rd_ready, pif.proc_rd_data_valid, pif.proc_rd_err});
        end
        n_checks++;
        if (pif.proc_rd_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", pif.proc_rd_data); end

        pif.proc_rd_en   = 1'b1;
        pif.proc_rd_addr = 22'h1234;
        tick();
        idle_inputs();
        n_checks++;
        if (pkt_out.rdrq !== {1'b1, 22'h1234}) begin n_fail++; $display("FAIL rst_rdrq: got %h want %h", pkt_out.rdrq, {1'b1, 22'h1234}); end
        repeat (3) tick();
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (pif.proc_rd_ready !== 1'b1 || pkt_out !== '0 || pif.proc_rd_data_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_read_reset: got rdy %b pkt %h vld %b want 1/0/0",
                               pif.proc_rd_ready, pkt_out, pif.proc_rd_data_valid);
        end
        tick();
        reset = 1'b0;
        tick();
        send_rsp(64'h55);
        tick();
        idle_inputs();
        n_checks++;
        if ({pif.proc_rd_data_valid, pif.proc_rd_err, pif.proc_rd_ready} !== 3'b011) begin
            n_fail++; $display("FAIL post_reset_rsp: got vld/err/rdy %b want 011",
                               {pif.proc_rd_data_valid, pif.proc_rd_err, pif.proc_rd_ready});
        end
        n_checks++;
        if (pif.proc_rd_data !== '0) begin n_fail++; $display("FAIL post_reset_data: got %h want 0", pif.proc_rd_data); end
    endtask

    task automatic test_write_burst();
        wr_packet_t exp;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pif.proc_wr_en   = 1'b1;
            pif.proc_wr_strb = 8'hFF;
            pif.proc_wr_addr = 22'(32'h100 + 8 * i);
            pif.proc_wr_data = 64'(32'hA0 + i);
            tick();
            exp.wr_en   = 1'b1;
            exp.wr_strb = 8'hFF;
            exp.wr_addr = 22'(32'h100 + 8 * i);
            exp.wr_data = 64'(32'hA0 + i);
            n_checks++;
            if (pkt_out.wr !== exp || pkt_out.rdrq !== '0) begin
                n_fail++; $display("FAIL wr_burst[%0d]: got wr %h rdrq %h want wr %h rdrq 0", i, pkt_out.wr, pkt_out.rdrq, exp);
            end
        end
        idle_inputs();
        tick();
        n_checks++;
        if (pkt_out.wr !== '0) begin n_fail++; $display("FAIL wr_after_burst: got %h want 0", pkt_out.wr); end
    endtask

    task automatic test_read();
        do_reset();
        pif.proc_rd_en   = 1'b1;
        pif.proc_rd_addr = 22'h2000;
        tick();
        idle_inputs();
        n_checks++;
        if (pkt_out.rdrq !== {1'b1, 22'h2000} || pif.proc_rd_ready !== 1'b0) begin
            n_fail++; $display("FAIL read_req: got rdrq %h rdy %b want %h rdy 0", pkt_out.rdrq, pif.proc_rd_ready, {1'b1, 22'h2000});
        end
        for (int c = 2; c <= 10; c++) begin
            tick();
            n_checks++;
            if (pif.proc_rd_data_valid !== 1'b0 || pif.proc_rd_ready !== 1'b0 || pkt_out.rdrq !== '0) begin
                n_fail++; $display("FAIL read_wait[%0d]: got vld %b rdy %b rdrq %h want 0/0/0",
                                   c, pif.proc_rd_data_valid, pif.proc_rd_ready, pkt_out.rdrq);
            end
        end
        send_rsp(64'hDEADBEEF_CAFEF00D);
        tick();
        idle_inputs();
        n_checks++;
        if (pif.proc_rd_data_valid !== 1'b1 || pif.proc_rd_data !== 64'hDEADBEEF_CAFEF00D ||
            pif.proc_rd_ready !== 1'b1 || pif.proc_rd_err !== 1'b0) begin
            n_fail++; $display("FAIL read_rsp: got vld %b data %h rdy %b err %b want 1/deadbeefcafef00d/1/0",
                               pif.proc_rd_data_valid, pif.proc_rd_data, pif.proc_rd_ready, pif.proc_rd_err);
        end
        tick();
        n_checks++;
        if (pif.proc_rd_data_valid !== 1'b0 || pif.proc_rd_data !== 64'hDEADBEEF_CAFEF00D || pkt_out.rdrs !== '0) begin
            n_fail++; $display("FAIL read_hold: got vld %b data %h rdrs %h want 0/deadbeefcafef00d/0",
                               pif.proc_rd_data_valid, pif.proc_rd_data, pkt_out.rdrs);
        end
    endtask

    task automatic test_read_busy();
        wr_packet_t exp;
        do_reset();
        pif.proc_rd_en   = 1'b1;
        pif.proc_rd_addr = 22'h40;
        pif.proc_wr_en   = 1'b1;
        pif.proc_wr_strb = 8'h3C;
        pif.proc_wr_addr = 22'h208;
        pif.proc_wr_data = 64'h1111_2222_3333_4444;
        tick();
        n_checks++;
        if (pkt_out.rdrq !== {1'b1, 22'h40} || pkt_out.wr !== {1'b1, 8'h3C, 22'h208, 64'h1111_2222_3333_4444}) begin
            n_fail++; $display("FAIL wr_rd_same: got wr %h rdrq %h", pkt_out.wr, pkt_out.rdrq);
        end
        pif.proc_rd_addr = 22'h80;
        pif.proc_wr_strb = 8'h0F;
        pif.proc_wr_addr = 22'h300;
        pif.proc_wr_data = 64'h77;
        tick();
        idle_inputs();
        exp.wr_en   = 1'b1;
        exp.wr_strb = 8'h0F;
        exp.wr_addr = 22'h300;
        exp.wr_data = 64'h77;
        n_checks++;
        if (pkt_out.rdrq !== '0 || pkt_out.wr !== exp || pif.proc_rd_err !== 1'b0) begin
            n_fail++; $display("FAIL busy_read: got rdrq %h wr %h err %b want rdrq 0 wr %h err 0",
                               pkt_out.rdrq, pkt_out.wr, pif.proc_rd_err, exp);
        end
        send_rsp(64'h0123_4567_89AB_CDEF);
        tick();
        idle_inputs();
        n_checks++;
        if (pif.proc_rd_data_valid !== 1'b1 || pif.proc_rd_data !== 64'h0123_4567_89AB_CDEF) begin
            n_fail++; $display("FAIL busy_rsp: got vld %b data %h want 1/0123456789abcdef",
                               pif.proc_rd_data_valid, pif.proc_rd_data);
        end
    endtask

    task automatic test_stray();
        do_reset();
        send_rsp(64'hBAD);
        tick();
        idle_inputs();
        n_checks++;
        if (pif.proc_rd_data_valid !== 1'b0 || pif.proc_rd_err !== 1'b1 || pif.proc_rd_data !== '0) begin
            n_fail++; $display("FAIL stray: got vld %b err %b data %h want 0/1/0",
                               pif.proc_rd_data_valid, pif.proc_rd_err, pif.proc_rd_data);
        end
        repeat (3) tick();
        n_checks++;
        if (pif.proc_rd_err !== 1'b1) begin n_fail++; $display("FAIL stray_sticky: got err %b want 1", pif.proc_rd_err); end

        do_reset();
        pif.proc_rd_en   = 1'b1;
        pif.proc_rd_addr = 22'h3F_FFFF;
        send_rsp(64'hFEED);
        tick();
        idle_inputs();
        n_checks++;
        if (pkt_out.rdrq !== {1'b1, 22'h3F_FFFF} || pif.proc_rd_data_valid !== 1'b0 ||
            pif.proc_rd_err !== 1'b1 || pif.proc_rd_ready !== 1'b0) begin
            n_fail++; $display("FAIL accept_same_rsp: got rdrq %h vld %b err %b rdy %b want 7fffff/0/1/0",
                               pkt_out.rdrq, pif.proc_rd_data_valid, pif.proc_rd_err, pif.proc_rd_ready);
        end
        send_rsp(64'hBEEF);
        tick();
        idle_inputs();
        n_checks++;
        if (pif.proc_rd_data_valid !== 1'b1 || pif.proc_rd_data !== 64'hBEEF) begin
            n_fail++; $display("FAIL accept_same_late: got vld %b data %h want 1/beef", pif.proc_rd_data_valid, pif.proc_rd_data);
        end
    endtask

`ifdef GLB_PROC_RD_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        pif.proc_rd_en   = 1'b1;
        pif.proc_rd_addr = 22'h500;
        tick();
        idle_inputs();
        for (int c = 1; c <= TO_CYCLES; c++) begin
            tick();
            n_checks++;
            if (pif.proc_rd_data_valid !== 1'b0 || pif.proc_rd_err !== 1'b0) begin
                n_fail++; $display("FAIL to_early[%0d]: got vld %b err %b want 0/0", c, pif.proc_rd_data_valid, pif.proc_rd_err);
            end
        end
        tick();
        n_checks++;
        if (pif.proc_rd_data_valid !== 1'b1 || pif.proc_rd_data !== '0 ||
            pif.proc_rd_err !== 1'b1 || pif.proc_rd_ready !== 1'b1) begin
            n_fail++; $display("FAIL to_fire: got vld %b data %h err %b rdy %b want 1/0/1/1",
                               pif.proc_rd_data_valid, pif.proc_rd_data, pif.proc_rd_err, pif.proc_rd_ready);
        end

        do_reset();
        pif.proc_rd_en   = 1'b1;
        pif.proc_rd_addr = 22'h504;
        tick();
        idle_inputs();
        repeat (TO_CYCLES) tick();
        send_rsp(64'h600D_D474);
        tick();
        idle_inputs();
        n_checks++;
        if (pif.proc_rd_data_valid !== 1'b1 || pif.proc_rd_data !== 64'h600D_D474 || pif.proc_rd_err !== 1'b0) begin
            n_fail++; $display("FAIL to_race: got vld %b data %h err %b want 1/600dd474/0",
                               pif.proc_rd_data_valid, pif.proc_rd_data, pif.proc_rd_err);
        end
    endtask
`else
    task automatic test_no_timeout();
        int seen_valid = 0;
        do_reset();
        pif.proc_rd_en   = 1'b1;
        pif.proc_rd_addr = 22'h700;
        tick();
        idle_inputs();
        repeat (300) begin
            tick();
            if (pif.proc_rd_data_valid === 1'b1) seen_valid++;
        end
        n_checks++;
        if (seen_valid != 0 || pif.proc_rd_ready !== 1'b0 || pif.proc_rd_err !== 1'b0) begin
            n_fail++; $display("FAIL no_timeout: got valids %0d rdy %b err %b want 0/0/0",
                               seen_valid, pif.proc_rd_ready, pif.proc_rd_err);
        end
        send_rsp(64'h7777);
        tick();
        idle_inputs();
        n_checks++;
        if (pif.proc_rd_data_valid !== 1'b1 || pif.proc_rd_data !== 64'h7777) begin
            n_fail++; $display("FAIL no_timeout_rsp: got vld %b data %h want 1/7777", pif.proc_rd_data_valid, pif.proc_rd_data);
        end
    endtask
`endif

    // Transaction-level model: one read in flight at most; anything answering nothing is an error.
    task automatic test_random();
        packet_t                    exp_pkt;
        bit                         busy     = 0;
        int                         waited   = 0;
        bit                         exp_err  = 0;
        bit                         exp_vld;
        logic [BANK_DATA_WIDTH-1:0] exp_data = '0;
        bit                         answered, expired, accepted;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            pif.proc_wr_en            = 1'($urandom_range(0, 1));
            pif.proc_wr_strb          = 8'($urandom);
            pif.proc_wr_addr          = 22'($urandom);
            pif.proc_wr_data          = {$urandom, $urandom};
            pif.proc_rd_en            = ($urandom_range(0, 2) == 0);
            pif.proc_rd_addr          = 22'($urandom);
            pkt_in.rdrs.rd_data       = {$urandom, $urandom};
            pkt_in.rdrs.rd_data_valid = ($urandom_range(0, 5) == 0);

            exp_pkt = '0;
            if (pif.proc_wr_en)
                exp_pkt.wr = {1'b1, pif.proc_wr_strb, pif.proc_wr_addr, pif.proc_wr_data};
            accepted = pif.proc_rd_en && !busy;
            if (accepted)
                exp_pkt.rdrq = {1'b1, pif.proc_rd_addr};
            answered = busy && pkt_in.rdrs.rd_data_valid;
`ifdef GLB_PROC_RD_TIMEOUT_EN
            expired = busy && !answered && (waited == TO_CYCLES);
`else
            expired = 0;
`endif
            exp_vld = answered || expired;
            if (answered) exp_data = pkt_in.rdrs.rd_data;
            else if (expired) exp_data = '0;
            if ((pkt_in.rdrs.rd_data_valid && !busy) || expired) exp_err = 1;
            if (accepted) begin
                busy = 1; waited = 0;
            end else if (answered || expired) begin
                busy = 0;
            end else if (busy) begin
                waited++;
            end

            tick();
            n_checks++;
            if (pkt_out !== exp_pkt) begin n_fail++; $display("FAIL rnd_pkt[%0d]: got %h want %h", cyc, pkt_out, exp_pkt); end
            n_checks++;
            if (pif.proc_rd_ready !== !busy) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b", cyc, pif.proc_rd_ready, !busy); end
            n_checks++;
            if (pif.proc_rd_data_valid !== exp_vld) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", cyc, pif.proc_rd_data_valid, exp_vld); end
            n_checks++;
            if (pif.proc_rd_data !== exp_data) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h want %h", cyc, pif.proc_rd_data, exp_data); end
            n_checks++;
            if (pif.proc_rd_err !== exp_err) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b want %b", cyc, pif.proc_rd_err, exp_err); end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_write_burst();
        test_read();
        test_read_busy();
        test_stray();
`ifdef GLB_PROC_RD_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/glb_proc_packet_injector.md
Name: glb_proc_packet_injector

Overview:
Processor-side initiator at the west edge of the global buffer tile chain. It converts the processor's simple write and read bus into packet_t requests driven into tile 0's west input. It collects read-response packets returning on tile 0's west output and returns them to the processor. At most one read is outstanding at any time.

Parameters:
GLB_ADDR_WIDTH, 22, byte address width (package constant; port widths derive from it)
BANK_DATA_WIDTH, 64, data width of wr/rdrs payload (package constant)
BANK_STRB_WIDTH, 8, write byte-strobe width = BANK_DATA_WIDTH/8
RD_TIMEOUT_CYCLES, 256, cycles in RD_WAIT before forced completion (used only with the optional feature)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
proc_wr_en  in  1  write request, one beat per cycle, always accepted
proc_wr_strb  in  BANK_STRB_WIDTH  byte enables
proc_wr_addr  in  GLB_ADDR_WIDTH  write address
proc_wr_data  in  BANK_DATA_WIDTH  write data
proc_rd_en  in  1  read request; accepted only when proc_rd_ready=1
proc_rd_addr  in  GLB_ADDR_WIDTH  read address
proc_rd_ready  out  1  1 when no read is outstanding
proc_rd_data  out  BANK_DATA_WIDTH  read return data
proc_rd_data_valid  out  1  one-cycle pulse with read data
proc_rd_err  out  1  sticky; set by a stray response or a timeout; cleared only by reset
packet_w2e_esto  out  packet_t  request packet into tile 0 west input (wr, rdrq, rdrs fields)
packet_e2w_wsti  in  packet_t  packet from tile 0 west output; only the rdrs field is used

Behaviour:
- Reset: all outputs 0 except proc_rd_ready=1; state IDLE; all registers cleared.
- Reset asserted mid-read discards the transaction. No proc_rd_data_valid is produced for it.
- Write path: registered, latency 1.
  - When proc_wr_en=1 in cycle N, packet_w2e_esto.wr = {wr_en=1, strb, addr, data} in cycle N+1.
  - Otherwise wr is all-zero in N+1.
  - No backpressure; back-to-back writes produce back-to-back packets.
- Read request path: registered, latency 1.
  - A read is accepted when proc_rd_en=1 and state=IDLE.
  - In cycle N+1, packet_w2e_esto.rdrq = {rd_en=1, rd_addr}; otherwise rdrq is zero.
  - proc_rd_en while not ready is ignored. No packet is sent and the error flag is unchanged.
- Simultaneous write and read in the same cycle: both are issued in the same outgoing packet. The wr and rdrq fields are independent; there is no priority.
- packet_w2e_esto.rdrs is always driven 0. The injector never originates responses.
- FSM states:
  - IDLE -> RD_WAIT on an accepted read; proc_rd_ready drops to 0 in cycle N+1.
  - RD_WAIT -> IDLE when packet_e2w_wsti.rdrs.rd_data_valid=1.
- Response handling (response seen in cycle M):
  - In cycle M+1: proc_rd_data = rd_data, proc_rd_data_valid=1 for one cycle, proc_rd_ready=1.
  - A new read is acceptable in cycle M+1.
- proc_rd_data holds its last value when valid is low.
- Stray response (rd_data_valid=1 while IDLE): dropped, no valid pulse, proc_rd_err set in the next cycle.
- A response arriving in the same cycle a read is accepted belongs to no outstanding read. It is treated as stray.

Optional Feature:
GLB_PROC_RD_TIMEOUT_EN
- Defined:
  - A counter of width $clog2(RD_TIMEOUT_CYCLES+1) clears on RD_WAIT entry and increments each cycle in RD_WAIT.
  - When the counter reaches RD_TIMEOUT_CYCLES with no response, the read is forced complete. Next cycle: proc_rd_data=0, proc_rd_data_valid=1, proc_rd_err=1, state IDLE.
  - A response arriving in the same cycle as the timeout wins: normal completion, no error.
  - A response arriving after the timeout is treated as stray.
- Not defined: no counter exists and RD_WAIT persists until a response arrives.

Decomposition:
- global_buffer_pkg: packet_t, wr_packet_t, rdrq_packet_t, rdrs_packet_t (these struct typedefs already exist there).
- global_buffer_param: GLB_ADDR_WIDTH, BANK_DATA_WIDTH, BANK_STRB_WIDTH.
- New enum rd_state_e {IDLE, RD_WAIT} goes in global_buffer_pkg.
- One sub-module: glb_proc_rd_tracker (FSM, timeout counter, response capture, error flag). The top level keeps the write/rdrq output registers.

Test Plan:
- Reset: assert reset mid-RD_WAIT -> all outputs 0, proc_rd_ready=1; a later rdrs with valid=1 only sets proc_rd_err.
- Write burst: wr_en for 4 cycles, addr 0x100..0x118, data 0xA0..0xA3, strb 0xFF -> wr packets appear cycles 1-4 with matching fields; rdrq=0 throughout.
- Read: rd_addr=0x2000 at cycle 0 -> rdrq {1,0x2000} at cycle 1, ready=0. Drive rdrs {data=0xDEADBEEF_CAFEF00D, valid=1} at cycle 10 -> valid pulse with that data at cycle 11, ready=1.
- Read while busy plus simultaneous write: second rd_en during RD_WAIT -> no rdrq is emitted. A same-cycle wr_en still produces a wr packet.
- Stray response in IDLE: valid=1 -> no proc_rd_data_valid; proc_rd_err=1 next cycle and it stays set.
- With GLB_PROC_RD_TIMEOUT_EN and RD_TIMEOUT_CYCLES=8: read with no response -> valid with data 0 and err=1 exactly 9 cycles after the rdrq cycle. Repeat with the response on the timeout cycle -> normal data, err=0.
